video_pattern_gen: RTL and testbench

- Native-RTL AXI4-Stream video test-pattern source; replaces the vendor TPG core and its AXI4-Lite init sequencer.
- Resolution, component width and checker size are parameters. Pattern, solid colour and run mode are live inputs, sampled only at frame boundaries.
- Sits upstream of the video-to-native/HDMI output path; drives one 3-component pixel per beat with SOF on TUSER and EOL on TLAST.

---
 rtl/video_pkg.sv | 37 +++
 rtl/video_pattern_pixel.sv | 63 ++++++
 rtl/video_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern source.
package video_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID   = 3'd0,
    PAT_HRAMP   = 3'd1,
    PAT_VRAMP   = 3'd2,
    PAT_BARS    = 3'd3,
    PAT_CHECKER = 3'd4
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Colour-bar on/off masks, bit 2 = R, bit 1 = G, bit 0 = B
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  localparam logic [7:0][2:0] BAR_MASKS = {
    BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
    BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE
  };

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator: (x, y, pattern, solid) -> {R,G,B}.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int COMP_W   = 8,
  parameter int CHK_LOG2 = 4,
  parameter int XW       = clog2_min1(H_ACTIVE),
  parameter int YW       = clog2_min1(V_ACTIVE)
) (
  input  logic [XW-1:0]       x,
  input  logic [YW-1:0]       y,
  input  pattern_t            pattern,
  input  logic [3*COMP_W-1:0] solid,
  output logic [3*COMP_W-1:0] pixel
);

  logic [7:1] bar_ge;
  logic [2:0] bar_idx;
  logic [2:0] bar_mask;
  logic       chk_x;
  logic       chk_y;
  logic       unused_y;

  // Bar index = number of constant bar boundaries already passed
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_ge[gi] = (x >= XW'(gi * (H_ACTIVE / 8)));
  end

  // Checker bit positions beyond the counter width read as zero
  if (CHK_LOG2 < XW) begin : g_chk_x
    assign chk_x = x[CHK_LOG2];
  end else begin : g_chk_x0
    assign chk_x = 1'b0;
  end

  if (CHK_LOG2 < YW) begin : g_chk_y
    assign chk_y = y[CHK_LOG2];
  end else begin : g_chk_y0
    assign chk_y = 1'b0;
  end

  assign unused_y = ^y;

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      bar_idx = bar_idx + 3'(bar_ge[i]);
    end
    bar_mask = BAR_MASKS[bar_idx];
    pixel    = '0;
    case (pattern)
      PAT_SOLID:   pixel = solid;
      PAT_HRAMP:   pixel = {3{COMP_W'(x)}};
      PAT_VRAMP:   pixel = {3{COMP_W'(y)}};
      PAT_BARS:    pixel = {{COMP_W{bar_mask[2]}}, {COMP_W{bar_mask[1]}}, {COMP_W{bar_mask[0]}}};
      PAT_CHECKER: pixel = {(3*COMP_W){chk_x ^ chk_y}};
      default:     pixel = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream video test-pattern source with frame-atomic run control.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int COMP_W   = 8,
  parameter int CHK_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                enable_i,
  input  logic                single_i,
  input  logic [2:0]          pattern_i,
  input  logic [3*COMP_W-1:0] solid_i,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [15:0]         frame_cnt_o,
  output logic                m_axis_video_TVALID,
  input  logic                m_axis_video_TREADY,
  output logic [3*COMP_W-1:0] m_axis_video_TDATA,
  output logic                m_axis_video_TUSER,
  output logic                m_axis_video_TLAST
);

  localparam int XW = clog2_min1(H_ACTIVE);
  localparam int YW = clog2_min1(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_t              state_reg, state_next;
  logic [XW-1:0]       x_reg, x_next;
  logic [YW-1:0]       y_reg, y_next;
  pattern_t            pat_reg, pat_next;
  logic [3*COMP_W-1:0] solid_reg, solid_next;
  logic                single_reg, single_next;
  logic                tvalid_reg, tuser_reg, tlast_reg, done_reg;
  logic [3*COMP_W-1:0] tdata_reg;
  logic [15:0]         cnt_reg;
  logic [3*COMP_W-1:0] pix;
  logic                hs, last_beat, frame_end, restart, advance;

  assign hs        = tvalid_reg & m_axis_video_TREADY;
  assign last_beat = (x_reg == X_LAST) && (y_reg == Y_LAST);
  assign frame_end = (state_reg == ST_RUN) && hs && last_beat;
  assign restart   = ((state_reg == ST_IDLE) && enable_i) ||
                     (frame_end && enable_i && !single_reg);
  assign advance   = (state_reg == ST_RUN) && hs && !last_beat;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable_i) state_next = ST_RUN;
      ST_RUN:  if (frame_end && !(enable_i && !single_reg)) state_next = ST_DONE;
      ST_DONE: if (!enable_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_reg == ST_RUN);
  end

  // Beat coordinates and latched frame settings for the beat presented next
  always_comb begin
    x_next      = x_reg;
    y_next      = y_reg;
    pat_next    = pat_reg;
    solid_next  = solid_reg;
    single_next = single_reg;
    if (restart) begin
      x_next      = '0;
      y_next      = '0;
      pat_next    = pattern_t'(pattern_i);
      solid_next  = solid_i;
      single_next = single_i;
    end else if (advance) begin
      if (x_reg == X_LAST) begin
        x_next = '0;
        y_next = y_reg + YW'(1);
      end else begin
        x_next = x_reg + XW'(1);
      end
    end
  end

  video_pattern_pixel #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .COMP_W  (COMP_W),
    .CHK_LOG2(CHK_LOG2),
    .XW      (XW),
    .YW      (YW)
  ) u_pixel (
    .x      (x_next),
    .y      (y_next),
    .pattern(pat_next),
    .solid  (solid_next),
    .pixel  (pix)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      x_reg      <= '0;
      y_reg      <= '0;
      pat_reg    <= PAT_SOLID;
      solid_reg  <= '0;
      single_reg <= 1'b0;
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tuser_reg  <= 1'b0;
      tlast_reg  <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      x_reg      <= x_next;
      y_reg      <= y_next;
      pat_reg    <= pat_next;
      solid_reg  <= solid_next;
      single_reg <= single_next;
      tvalid_reg <= (state_next == ST_RUN);
      done_reg   <= frame_end;
      if (restart || advance) begin
        tdata_reg <= pix;
        tuser_reg <= (x_next == '0) && (y_next == '0);
        tlast_reg <= (x_next == X_LAST);
      end
      if (frame_end) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign m_axis_video_TVALID = tvalid_reg;
  assign m_axis_video_TDATA  = tdata_reg;
  assign m_axis_video_TUSER  = tuser_reg;
  assign m_axis_video_TLAST  = tlast_reg;
  assign frame_done_o        = done_reg;
  assign frame_cnt_o         = cnt_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomized bench for video_pattern_gen against a frame-level reference model.
module tb_video_pattern_gen;

  localparam int H   = 16;
  localparam int V   = 4;
  localparam int CW  = 8;
  localparam int CHK = 2;
  localparam int NB  = H * V;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
    int          c;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, enable, single;
  logic [2:0]  pattern;
  logic [23:0] solid;
  logic        busy, frame_done;
  logic [15:0] frame_cnt;
  logic        tvalid, tready, tuser, tlast;
  logic [23:0] tdata;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_seen = 0;
  int          exp_frames = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_word = '0;
  bit          rand_ready = 1'b0;
  beat_t       got[$];
  beat_t       ref_run[$];

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COMP_W(CW), .CHK_LOG2(CHK)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .enable_i           (enable),
    .single_i           (single),
    .pattern_i          (pattern),
    .solid_i            (solid),
    .busy_o             (busy),
    .frame_done_o       (frame_done),
    .frame_cnt_o        (frame_cnt),
    .m_axis_video_TVALID(tvalid),
    .m_axis_video_TREADY(tready),
    .m_axis_video_TDATA (tdata),
    .m_axis_video_TUSER (tuser),
    .m_axis_video_TLAST (tlast)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int pat, input logic [23:0] s, input int x, input int y);
    logic [7:0]  c;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (pat)
      0: return s;
      1: begin c = 8'(x % 256); return {c, c, c}; end
      2: begin c = 8'(y % 256); return {c, c, c}; end
      3: return bars[x / (H / 8)];
      4: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  // One clock: sample at negedge, check holds, pick TREADY, log handshakes
  task automatic step();
    beat_t b;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("hold", {5'd0, tvalid, tuser, tlast, tdata}, hold_word);
      if (frame_done) done_seen++;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && tready) begin
        b.d = tdata; b.u = tuser; b.l = tlast; b.c = cyc;
        got.push_back(b);
      end
      hold_v    = tvalid && !tready;
      hold_word = {5'd0, tvalid, tuser, tlast, tdata};
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      step();
      c++;
    end
    check("beat_count", got.size(), n);
  endtask

  task automatic check_frame(input int base, input int pat, input logic [23:0] s, input string tag);
    int x, y;
    logic [25:0] e;
    if (got.size() < base + NB) begin
      check({tag, "_short"}, got.size(), base + NB);
      return;
    end
    for (int i = 0; i < NB; i++) begin
      x = i % H;
      y = i / H;
      e = {(x == 0 && y == 0), (x == H - 1), model_pix(pat, s, x, y)};
      check($sformatf("%s_b%0d", tag, i), {6'd0, got[base+i].u, got[base+i].l, got[base+i].d}, {6'd0, e});
    end
    $display("frame %s pattern=%0d beats=%0d cnt=%0d", tag, pat, got.size() - base, frame_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tdata"}, tdata, 0);
    check({tag, "_tuser"}, tuser, 0);
    check({tag, "_tlast"}, tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_cnt"}, frame_cnt, 0);
  endtask

  task automatic launch(input int pat, input logic [23:0] s, input bit sgl);
    pattern = 3'(pat);
    solid   = s;
    single  = sgl;
    check("pre_tvalid", tvalid, 0);
    enable = 1'b1;
    step();
    check("lat_tvalid", tvalid, 1);
    check("lat_tuser", tuser, 1);
    if (sgl) enable = 1'b0;
  endtask

  task automatic finish_single(input int base, input int budget);
    wait_beats(base + NB, budget);
    repeat (3) step();
    exp_frames++;
    check("end_tvalid", tvalid, 0);
    check("end_busy", busy, 0);
    check("end_cnt", frame_cnt, exp_frames);
  endtask

  initial begin
    int          base, d0;
    int          pat;
    logic [23:0] s;

    rst_n = 1'b0; enable = 1'b0; single = 1'b0;
    pattern = '0; solid = '0; tready = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Horizontal ramp, single shot, back-to-back
    base = got.size(); d0 = done_seen;
    launch(1, 24'h0, 1'b1);
    finish_single(base, 500);
    check_frame(base, 1, 24'h0, "hramp");
    if (got.size() >= base + NB) begin
      check("hramp_b15", got[base+15].d, 24'h0F0F0F);
      check("hramp_b2b", got[base+NB-1].c - got[base].c, NB - 1);
      for (int i = 0; i < NB; i++) ref_run.push_back(got[base+i]);
    end
    check("hramp_done_pulses", done_seen - d0, 1);

    // Colour bars
    base = got.size();
    launch(3, 24'h0, 1'b1);
    finish_single(base, 500);
    check_frame(base, 3, 24'h0, "bars");
    if (got.size() >= base + NB) begin
      check("bars_b0", got[base+0].d, 24'hFFFFFF);
      check("bars_b1", got[base+1].d, 24'hFFFFFF);
      check("bars_b2", got[base+2].d, 24'hFFFF00);
      check("bars_b3", got[base+3].d, 24'hFFFF00);
      check("bars_b14", got[base+14].d, 24'h000000);
      check("bars_b15", got[base+15].d, 24'h000000);
    end

    // Random TREADY backpressure, random patterns and colours
    rand_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pat  = (k == 0) ? 1 : $urandom_range(0, 7);
      s    = (k == 0) ? 24'h0 : 24'($urandom);
      base = got.size();
      launch(pat, s, 1'b1);
      finish_single(base, 3000);
      check_frame(base, pat, s, $sformatf("rand%0d", k));
      if (k == 0 && got.size() >= base + NB && ref_run.size() == NB)
        for (int i = 0; i < NB; i++)
          check($sformatf("rand_vs_ready_b%0d", i), got[base+i].d, ref_run[i].d);
    end
    rand_ready = 1'b0;
    step();

    // Continuous mode with a mid-frame pattern change
    s    = 24'($urandom);
    base = got.size();
    launch(0, s, 1'b0);
    wait_beats(base + 10, 200);
    pattern = 3'd2;
    wait_beats(base + 70, 200);
    check("cont_cnt_mid", frame_cnt, exp_frames + 1);
    enable = 1'b0;
    wait_beats(base + 2 * NB, 500);
    repeat (5) step();
    exp_frames += 2;
    check("cont_beats", got.size(), base + 2 * NB);
    check_frame(base, 0, s, "cont_f1");
    check_frame(base + NB, 2, s, "cont_f2");
    if (got.size() >= base + 2 * NB)
      check("cont_no_gap", got[base+2*NB-1].c - got[base].c, 2 * NB - 1);
    check("cont_cnt", frame_cnt, exp_frames);
    check("cont_tvalid", tvalid, 0);
    check("cont_busy", busy, 0);

    // Enable dropped mid-frame: frame still completes, then stops
    base = got.size();
    launch(4, 24'h0, 1'b0);
    wait_beats(base + 10, 200);
    enable = 1'b0;
    wait_beats(base + NB, 500);
    repeat (10) step();
    exp_frames++;
    check("drop_beats", got.size(), base + NB);
    check_frame(base, 4, 24'h0, "drop");
    check("drop_cnt", frame_cnt, exp_frames);
    check("drop_tvalid", tvalid, 0);
    check("drop_busy", busy, 0);

    // Reset at beat 20 of a frame
    base = got.size();
    launch(1, 24'h0, 1'b1);
    wait_beats(base + 20, 200);
    check("rst_pre_tvalid", tvalid, 1);
    rst_n = 1'b0;
    step();
    check_zero("midrst");
    rst_n = 1'b1;
    exp_frames = 0;
    repeat (3) step();
    check("midrst_idle_tvalid", tvalid, 0);
    base = got.size();
    launch(1, 24'h0, 1'b1);
    finish_single(base, 500);
    check_frame(base, 1, 24'h0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
